// File: rtl/r5p_soc_ctl_pkg.sv
// Shared constants for the SoC controller: register byte offsets and the
// bit layout of the STATUS register.
package r5p_soc_ctl_pkg;

   localparam logic [7:0] CTL_DATA_BEGIN = 8'h00;
   localparam logic [7:0] CTL_DATA_END   = 8'h04;
   localparam logic [7:0] CTL_HALT       = 8'h08;
   localparam logic [7:0] CTL_CON_TX     = 8'h0C;
   localparam logic [7:0] CTL_STATUS     = 8'h10;
   localparam logic [7:0] CTL_CYCLE_LO   = 8'h14;
   localparam logic [7:0] CTL_CYCLE_HI   = 8'h18;

   localparam int STS_FULL      = 0;
   localparam int STS_EMPTY     = 1;
   localparam int STS_LEVEL_LSB = 8;
   localparam int STS_LEVEL_W   = 8;

endpackage

// File: rtl/r5p_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the level is the pointer
// difference, so it spans 0..FD inclusive.
module r5p_fifo #(
   parameter int DW = 8,
   parameter int FD = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DW-1:0]         din,
   output logic                  full,
   input  logic                  pop,
   output logic [DW-1:0]         dout,
   output logic                  empty,
   output logic [$clog2(FD):0]   level
);

   localparam int AW = $clog2(FD);
   localparam int PW = AW + 1;

   logic [DW-1:0] mem [FD];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + PW'(1);
         if (pop && !empty)
            rptr <= rptr + PW'(1);
      end
   end

   // Storage is not reset: emptiness is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wptr[AW-1:0]] <= din;
   end

   assign level = wptr - rptr;
   assign full  = (level == PW'(FD));
   assign empty = (wptr == rptr);
   assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/r5p_soc_ctl.sv
// Simulation/SoC controller slave: signature bounds, sticky halt, buffered
// console TX with backpressure and a 64-bit cycle counter with coherent reads.
module r5p_soc_ctl
   import r5p_soc_ctl_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int SW = DW/8,
   parameter int FD = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          wen,
   input  logic [AW-1:0] adr,
   input  logic [SW-1:0] sel,
   input  logic [DW-1:0] wdt,
   output logic [DW-1:0] rdt,
   output logic          ack,
   output logic [DW-1:0] data_begin,
   output logic [DW-1:0] data_end,
   output logic          halt,
   output logic          con_vld,
   output logic [7:0]    con_dat,
   input  logic          con_rdy
);

   localparam int LW = $clog2(FD) + 1;

   logic [7:0]    off;
   logic          unused_adr;
   logic          wr;
   logic          rd;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [LW-1:0] fifo_level;
   logic [63:0]   cnt;
   logic [31:0]   cnt_hi;
   logic [DW-1:0] rd_val;

   assign off        = 8'({adr[AW-1:2], 2'b00});
   assign unused_adr = ^adr[1:0];

   // Only a console write into a full FIFO stalls; the full flag is
   // registered, so a pop in the stalled cycle frees the slot one cycle later.
   assign ack  = !(req && wen && (off == CTL_CON_TX) && fifo_full);
   assign wr   = req && ack && wen;
   assign rd   = req && ack && !wen;
   assign push = wr && (off == CTL_CON_TX) && sel[0];
   assign pop  = con_vld && con_rdy;

   r5p_fifo #(.DW(8), .FD(FD)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (wdt[7:0]),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (con_dat),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign con_vld = !fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_begin <= '0;
         data_end   <= '0;
         halt       <= 1'b0;
      end else if (wr) begin
         case (off)
            CTL_DATA_BEGIN:
               for (int i = 0; i < SW; i++)
                  if (sel[i]) data_begin[8*i +: 8] <= wdt[8*i +: 8];
            CTL_DATA_END:
               for (int i = 0; i < SW; i++)
                  if (sel[i]) data_end[8*i +: 8] <= wdt[8*i +: 8];
            CTL_HALT:
               if (sel[0] && wdt[0]) halt <= 1'b1;
            default: ;
         endcase
      end
   end

   // Reading the low word snapshots the high word so a later CYCLE_HI read
   // pairs with it even if a carry ripples in between.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         cnt_hi <= '0;
      end else begin
         cnt <= cnt + 64'd1;
         if (rd && (off == CTL_CYCLE_LO))
            cnt_hi <= cnt[63:32];
      end
   end

   always_comb begin
      rd_val = '0;
      case (off)
         CTL_DATA_BEGIN: rd_val = data_begin;
         CTL_DATA_END:   rd_val = data_end;
         CTL_HALT:       rd_val[0] = halt;
         CTL_STATUS: begin
            rd_val[STS_FULL]  = fifo_full;
            rd_val[STS_EMPTY] = fifo_empty;
            rd_val[STS_LEVEL_LSB +: STS_LEVEL_W] = STS_LEVEL_W'(fifo_level);
         end
         CTL_CYCLE_LO:   rd_val = cnt[31:0];
         CTL_CYCLE_HI:   rd_val = cnt_hi;
         default:        rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rdt <= '0;
      else if (rd)
         rdt <= rd_val;
   end

endmodule

// File: doc/r5p_soc_ctl.md
Name: r5p_soc_ctl

Overview:
Memory-mapped simulation/SoC controller slave on the load/store bus, directly downstream of the load/store bus decoder's controller port.
- Holds the signature region bounds and the sticky halt flag.
- Provides a buffered console TX channel with backpressure.
- Provides a coherent-read 64-bit cycle counter.
- The testbench or top level consumes halt, the signature bounds and the console stream.

Parameters:
AW, 5, load/store address width seen by this slave (byte address)
DW, 32, data width; fixed at 32
SW, DW/8, byte select width
FD, 16, console FIFO depth; power of two, at least 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
req  input  1  bus transfer request
wen  input  1  write enable (1 write, 0 read)
adr  input  AW  byte address; only adr[AW-1:2] decoded
sel  input  SW  byte select
wdt  input  DW  write data
rdt  output  DW  read data
ack  output  1  bus acknowledge
data_begin  output  DW  signature start address
data_end  output  DW  signature end address
halt  output  1  sticky halt request
con_vld  output  1  console byte valid
con_dat  output  8  console byte
con_rdy  input  1  console consumer ready

Behaviour:
Reset (rst=0, asynchronous):
- rdt, data_begin, data_end, halt, con_vld, cycle counter and high shadow all clear to 0.
- FIFO is emptied.
- Reset mid-operation discards queued console bytes; no partial transfer completes.

Handshake:
- A transfer occurs in a cycle where req & ack.
- ack is 1 in every cycle, except when req & wen & adr targets 0x0C & FIFO full; ack is then 0.
- A pop in that same cycle does not lift the stall; ack rises the next cycle.

Read timing:
- rdt is registered and valid in the cycle after the read transfer.
- rdt holds its value when no read transfer occurs.

Register map (word offsets):
- 0x00 DATA_BEGIN, RW: per-byte write under sel.
- 0x04 DATA_END, RW: per-byte write under sel.
- 0x08 HALT, RW: write with sel[0] & wdt[0] sets halt. halt stays 1 until reset; writing 0 is ignored. Reads return {31'b0, halt}.
- 0x0C CON_TX, WO: write with sel[0] pushes wdt[7:0]; with sel[0]=0 nothing is pushed. Reads return 0.
- 0x10 STATUS, RO: bit0 = full, bit1 = empty, bits[15:8] = FIFO level, other bits 0.
- 0x14 CYCLE_LO, RO: returns counter[31:0]. The same read copies counter[63:32] into the high shadow.
- 0x18 CYCLE_HI, RO: returns the high shadow.

Unmapped offsets and writes to RO registers:
- ack = 1.
- Writes are ignored; reads return 0.

Cycle counter:
- 64-bit, increments every cycle out of reset.
- Wraps from 2^64-1 to 0.
- Value sampled for a read is the value in the transfer cycle.

Console FIFO:
- Head is presented on con_dat; con_vld = !empty.
- Pop occurs on con_vld & con_rdy.
- A push into an empty FIFO gives con_vld=1 in the next cycle (no bypass).
- Simultaneous push and pop when not full: level unchanged, order preserved.
- Pointers are log2(FD) bits plus 1 wrap bit. Level is 0..FD.
- con_dat is don't-care while con_vld=0.

Decomposition:
- Package r5p_soc_ctl_pkg: register offset localparams (CTL_DATA_BEGIN=0x00 … CTL_CYCLE_HI=0x18) and the STATUS bit-position constants.
- Sub-module r5p_fifo (DW, FD parameters; push/full, pop/empty, level): a synchronous FIFO, reusable elsewhere.
- The top module holds register decode, counter and read mux.

Test Plan:
- Reset then write 0x00=0x0001_0000, 0x04=0x0001_0100 with sel=1111 → data_begin/data_end match; reads return the same values one cycle after ack.
- Write 0x04 with sel=0010 and wdt=0xAABB_CCDD → data_end becomes 0x0001_CC00; other bytes unchanged.
- Hold con_rdy=0 and push 16 bytes 0x41..0x50 → STATUS=0x0000_1001. A 17th write sees ack=0 until con_rdy=1 for one pop, then completes. Drain order is 0x41..0x51.
- Push and pop in the same cycle at level 5 → level stays 5; the pushed byte appears after the older 5.
- Force counter to 0x0000_0000_FFFF_FFFF; read CYCLE_LO, then CYCLE_HI 3 cycles later → 0xFFFF_FFFF then 0x0000_0000 (shadow coherent across the carry).
- Write HALT=1 with 3 bytes queued, then write HALT=0 → halt stays 1. Assert rst=0 mid-drain → con_vld=0, halt=0, STATUS=0x0000_0002 after release.
